// File: rtl/store_buffer_if.sv
// Store buffer port bundle: retire commit path, memory-FU load port and data-memory port.
// The master side is the memory FU/retire/memory environment; the slave side is the buffer.
interface store_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
        logic              MemRead;
        logic              MemWrite;
    } memReqStruct;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rd_data;
        logic              MemRead;
    } memRespStruct;

    logic                   commit_valid;
    logic [ADDR_W-1:0]      commit_addr;
    logic [DATA_W-1:0]      commit_data;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    memReqStruct            load_req;
    memRespStruct           load_resp;
    memReqStruct            mem_req;
    memRespStruct           mem_resp;

    modport master (
        output commit_valid, commit_addr, commit_data, load_req, mem_resp,
        input  full, count, load_resp, mem_req
    );

    modport slave (
        input  commit_valid, commit_addr, commit_data, load_req, mem_resp,
        output full, count, load_resp, mem_req
    );
endinterface

// File: rtl/store_buffer.sv
// Post-commit store FIFO with load forwarding; loads answer 1 cycle after request (hit or miss),
// stores drain one per cycle when no load misses; retire must hold stores while full is high.
module store_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pend_load_q, pend_load_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    logic              load_vld, push, drain, hit, resp_vld;
    logic [DATA_W-1:0] hit_data;

    assign sb.full  = (count_q == CNT_W'(DEPTH));
    assign sb.count = count_q;
    assign load_vld = sb.load_req.valid && sb.load_req.MemRead;
    assign push     = sb.commit_valid && !sb.full;
    assign drain    = (!load_vld || hit) && (count_q != '0);

    // Walk oldest to youngest so the last match wins; the same-cycle commit is younger still.
    always_comb begin : fwd_search
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (vld_q[idx] && (addr_q[idx] == sb.load_req.addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
        if (push && (sb.commit_addr == sb.load_req.addr)) begin
            hit      = 1'b1;
            hit_data = sb.commit_data;
        end
        if (!load_vld) begin
            hit = 1'b0;
        end
    end

    always_comb begin
        sb.mem_req = '0;
        if (load_vld && !hit) begin
            sb.mem_req.valid   = 1'b1;
            sb.mem_req.addr    = sb.load_req.addr;
            sb.mem_req.MemRead = 1'b1;
        end else if (drain) begin
            sb.mem_req.valid    = 1'b1;
            sb.mem_req.addr     = addr_q[head_q];
            sb.mem_req.wr_data  = data_q[head_q];
            sb.mem_req.MemWrite = 1'b1;
        end
        if (!rst_n) begin
            sb.mem_req.valid = 1'b0;
        end
    end

    always_comb begin
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(drain);
        if (drain) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PTR_W'(1);
        end
        pend_load_d = load_vld && !hit;
        fwd_valid_d = hit;
        fwd_data_d  = hit_data;
    end

    // Write acknowledgements carry MemRead=0 and never become a load response.
    assign resp_vld = (pend_load_q && sb.mem_resp.valid && sb.mem_resp.MemRead) || fwd_valid_q;

    always_comb begin
        sb.load_resp         = '0;
        sb.load_resp.valid   = resp_vld;
        sb.load_resp.rd_data = fwd_valid_q ? fwd_data_q : sb.mem_resp.rd_data;
        sb.load_resp.MemRead = resp_vld;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            pend_load_q <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            vld_q       <= vld_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pend_load_q <= pend_load_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= sb.commit_addr;
            data_q[tail_q] <= sb.commit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fwd_valid_q && pend_load_q))
                else $error("store_buffer: forward and pending load both active");
            assert (!(sb.commit_valid && sb.full))
                else $warning("store_buffer: commit dropped, buffer full");
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed stimulus against a queue-based store buffer model with a 1-cycle memory.
module tb_store_buffer;
    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) sbif ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sbif)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    st_t           sq[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] env_mem [logic [AW-1:0]];
    bit            er_vld = 1'b0;
    logic [DW-1:0] er_dat = '0;

    function automatic logic [DW-1:0] defval(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : defval(a);
    endfunction

    // Data memory: fixed 1-cycle latency, acknowledges writes with MemRead=0.
    always begin : mem_env
        logic          v, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        v = sbif.mem_req.valid;
        w = sbif.mem_req.MemWrite;
        a = sbif.mem_req.addr;
        d = sbif.mem_req.wr_data;
        @(posedge clk);
        #1;
        sbif.mem_resp = '0;
        if (v) begin
            sbif.mem_resp.valid = 1'b1;
            if (w) begin
                env_mem[a] = d;
            end else begin
                sbif.mem_resp.MemRead = 1'b1;
                sbif.mem_resp.rd_data = env_mem.exists(a) ? env_mem[a] : defval(a);
            end
        end
    end

    task automatic cycle(input bit rst, input bit cv, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input bit lv, input logic [AW-1:0] la);
        bit            hit, drain, push;
        logic [DW-1:0] hd;
        int            n;
        rst_n                = !rst;
        sbif.commit_valid    = cv;
        sbif.commit_addr     = ca;
        sbif.commit_data     = cd;
        sbif.load_req        = '0;
        sbif.load_req.valid  = lv;
        sbif.load_req.addr   = la;
        sbif.load_req.MemRead = 1'b1;

        n    = sq.size();
        push = !rst && cv && (n < DEPTH);
        hit  = 1'b0;
        hd   = '0;
        if (lv && !rst) begin
            if (push && ca == la) begin
                hit = 1'b1;
                hd  = cd;
            end else begin
                for (int i = n - 1; i >= 0; i--) begin
                    if (sq[i].a == la) begin
                        hit = 1'b1;
                        hd  = sq[i].d;
                        break;
                    end
                end
            end
        end
        drain = !rst && (n > 0) && (!lv || hit);

        @(negedge clk);
        chk("count", sbif.count, n);
        chk("full", sbif.full, n == DEPTH);
        chk("resp_vld", sbif.load_resp.valid, er_vld);
        if (er_vld) begin
            chk("resp_data", sbif.load_resp.rd_data, er_dat);
            chk("resp_rd", sbif.load_resp.MemRead, 1'b1);
        end
        if (rst) begin
            chk("req_vld_rst", sbif.mem_req.valid, 1'b0);
        end else if (lv && !hit) begin
            chk("rd_vld", sbif.mem_req.valid, 1'b1);
            chk("rd_addr", sbif.mem_req.addr, la);
            chk("rd_kind", {sbif.mem_req.MemRead, sbif.mem_req.MemWrite}, 2'b10);
        end else if (drain) begin
            chk("wr_vld", sbif.mem_req.valid, 1'b1);
            chk("wr_addr", sbif.mem_req.addr, sq[0].a);
            chk("wr_data", sbif.mem_req.wr_data, sq[0].d);
            chk("wr_kind", {sbif.mem_req.MemRead, sbif.mem_req.MemWrite}, 2'b01);
        end else begin
            chk("req_idle", sbif.mem_req.valid, 1'b0);
        end

        @(posedge clk);
        #1;
        if (rst) begin
            sq.delete();
            er_vld = 1'b0;
        end else begin
            er_vld = lv;
            er_dat = hit ? hd : ref_rd(la);
            if (drain) begin
                ref_mem[sq[0].a] = sq[0].d;
                void'(sq.pop_front());
            end
            if (push) sq.push_back(st_t'{a: ca, d: cd});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        sbif.commit_valid = 1'b0;
        sbif.commit_addr  = '0;
        sbif.commit_data  = '0;
        sbif.load_req     = '0;
        rst_n             = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
        idle(5);

        cycle(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, '0);
        idle(2);

        cycle(1'b0, 1'b1, 32'h200, 32'h11, 1'b1, 32'h500);
        cycle(1'b0, 1'b1, 32'h200, 32'h22, 1'b1, 32'h504);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 32'h200);
        idle(4);

        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'h700 + 4 * i, 32'hA000 + i, 1'b1, 32'h600);
        cycle(1'b0, 1'b1, 32'h800, 32'hBAD, 1'b1, 32'h600);
        idle(10);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h740 + 4 * i, 32'hB000 + i, 1'b1, 32'h604);
        idle(7);

        cycle(1'b0, 1'b1, 32'h300, 32'h55, 1'b1, 32'h300);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 32'h400);
        idle(4);

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h910 + 4 * i, 32'hC000 + i, 1'b1, 32'h900);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
        idle(4);

        for (int k = 0; k < 3000; k++) begin
            bit            cv, lv;
            logic [AW-1:0] ca, la;
            int            lp;
            lp = ((k / 200) % 3 == 0) ? 90 : 40;
            cv = ($urandom_range(0, 99) < 45) && (sq.size() < DEPTH);
            lv = $urandom_range(0, 99) < lp;
            ca = 32'h1000 + 4 * $urandom_range(0, 7);
            la = 32'h1000 + 4 * $urandom_range(0, 11);
            cycle(1'b0, cv, ca, $urandom, lv, la);
        end
        idle(DEPTH + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer between the memory functional unit's `memReqStruct` request port and the data memory. The memory FU only issues reads (`MemWrite` = 0) and carries store data to commit in `complete2.result`. Retired stores are pushed here, held in a circular FIFO and drained to memory one per cycle whenever no load needs the port. Loads that hit a buffered store get forwarded data, so a load response is always 1 cycle after the request.

## Interface
- DEPTH, 8, store entries; power of two, ≥2
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous reset, active low
- commit_valid  in  1  retired store to push this cycle
- commit_addr  in  ADDR_W  store address
- commit_data  in  DATA_W  store data
- full  out  1  count == DEPTH; retire must not commit a store while high
- count  out  $clog2(DEPTH)+1  occupied entries
- load_req  in  memReqStruct  request from the memory FU; a load is valid && MemRead
- load_resp  out  memRespStruct  response to the memory FU
- mem_req  out  memReqStruct  request to data memory
- mem_resp  in  memRespStruct  data memory response, fixed 1-cycle latency

## Operation
- **Storage:** DEPTH entries of {addr, data, valid}, plus head (oldest) and tail pointers of $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH.
  - count tracks occupancy separately, so full and empty are unambiguous.
- **Push:** on commit_valid && !full, write the entry at tail and increment tail.
  - commit_valid && full drops the store and fires an assertion; state is unchanged.
- **Forwarding check:** runs each cycle a load is valid.
  - Compare load_req.addr (full-width equality) against all valid entries and the same-cycle commit.
  - Priority is youngest first: the same-cycle commit, then entries from tail-1 back to head.
  - A hit selects that entry's data. Aliasing of different-size accesses is out of scope.
- **Port arbitration:** mem_req is combinational, one request per cycle.
  - Load miss: mem_req = {addr=load addr, MemRead=1, MemWrite=0, valid=1}. No drain this cycle.
  - Load hit: no memory access. fwd_valid and fwd_data are registered for the next cycle.
  - No load, or load hit, with count>0: drain the head with mem_req = {addr, wr_data=data, MemWrite=1, MemRead=0, valid=1}. Increment head and clear its valid bit at the edge.
  - Otherwise mem_req.valid = 0.
- **Count update:** count' = count + push − drain.
  - A simultaneous push and drain leaves count unchanged.
  - A push into an empty buffer cannot drain in the same cycle; the earliest drain is the next cycle.
- **Response:** pend_load is a registered flag set when a load miss is sent to memory.
  - load_resp.valid = (pend_load && mem_resp.valid) || fwd_valid.
  - rd_data comes from fwd_data when fwd_valid, else mem_resp.rd_data.
  - load_resp.MemRead = 1 whenever valid.
  - Write acknowledgements (mem_resp with MemRead=0) are discarded and never reach load_resp.
- **Invariant:** fwd_valid and pend_load are never both high. Assert this.

## Timing
- Store drain latency: a commit at edge N can be written to memory at the earliest in the cycle after N, if the port is free.
- Load response latency: exactly 1 cycle after load_req, for both the hit and miss paths.
- Back-to-back loads every cycle starve the drain. The drain resumes on the first load-free or hit cycle.
- Reset state (while rst_n low and at the following edge):
  - head = tail = count = 0, all valid bits cleared, full = 0.
  - pend_load = fwd_valid = 0, so load_resp.valid = 0.
  - mem_req.valid is forced to 0 while rst_n is low.
- Reset mid-drain: buffered stores are discarded. A write already presented to memory in that cycle is suppressed, because mem_req.valid is gated by rst_n.

## Test plan
- **Reset, then idle:** count=0, full=0, mem_req.valid=0 and load_resp.valid=0 for 5 cycles.
- **Single commit, no loads:** commit addr 0x100 data 0xDEADBEEF at cycle 1 → mem_req write {0x100, 0xDEADBEEF} in cycle 2; count 1→0.
- **Forward, youngest wins:** commit 0x200=0x11, then 0x200=0x22, while loads hold the port; then load 0x200 → load_resp 1 cycle later with rd_data=0x22 and no memory read issued.
- **Fill and overflow:** with DEPTH=8, commit 8 stores under continuous load misses → full=1, count=8. A 9th commit is dropped and the assertion fires. Release the loads → stores drain in commit order, with correct wrap on the next fill.
- **Same-cycle commit and load to 0x300:** commit data 0x55 → load_resp rd_data=0x55. A load miss to 0x400 returns mem_resp data, and write acknowledgements never raise load_resp.valid.
- **Reset with 3 entries pending:** count→0, and no write reaches memory after reset is asserted.
